// File: rtl/sc_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, variable-latency memory between
// the instruction-fetch port and the data port, with a per-access timeout abort.
module sc_mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ADD_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    // Handshake (both ports): a requester raises req with stable fields and
    // holds it until its one-cycle ack; ack (with err on timeout) completes it.
    input  logic               i_if_req,
    input  logic [ADD_W-1:0]   i_if_add,
    output logic [WIDTH-1:0]   o_if_rdata,
    output logic               o_if_ack,
    output logic               o_if_err,
    input  logic               i_d_req,
    input  logic               i_d_we,
    input  logic [ADD_W-1:0]   i_d_add,
    input  logic [WIDTH-1:0]   i_d_wdata,
    input  logic [WIDTH/8-1:0] i_d_be,
    output logic [WIDTH-1:0]   o_d_rdata,
    output logic               o_d_ack,
    output logic               o_d_err,
    output logic               o_m_req,
    output logic               o_m_we,
    output logic [ADD_W-1:0]   o_m_add,
    output logic [WIDTH-1:0]   o_m_wdata,
    output logic [WIDTH/8-1:0] o_m_be,
    input  logic [WIDTH-1:0]   i_m_rdata,
    input  logic               i_m_ack,
    output logic [1:0]         o_state
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             gnt;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic             any_req;
    logic             pick_d;

    // On contention the port that did not own the previous grant wins.
    always_comb begin
        any_req = i_if_req | i_d_req;
        pick_d  = i_d_req & (~i_if_req | ~last);
    end

    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last       <= 1'b0;
            cnt        <= '0;
            o_m_req    <= 1'b0;
            o_m_we     <= 1'b0;
            o_m_add    <= '0;
            o_m_wdata  <= '0;
            o_m_be     <= '0;
            o_if_ack   <= 1'b0;
            o_if_err   <= 1'b0;
            o_if_rdata <= '0;
            o_d_ack    <= 1'b0;
            o_d_err    <= 1'b0;
            o_d_rdata  <= '0;
        end else begin
            o_if_ack   <= 1'b0;
            o_if_err   <= 1'b0;
            o_if_rdata <= '0;
            o_d_ack    <= 1'b0;
            o_d_err    <= 1'b0;
            o_d_rdata  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= pick_d;
                        last    <= pick_d;
                        cnt     <= '0;
                        o_m_req <= 1'b1;
                        state   <= BUSY;
                        if (pick_d) begin
                            o_m_we    <= i_d_we;
                            o_m_add   <= i_d_add;
                            o_m_wdata <= i_d_wdata;
                            o_m_be    <= i_d_be;
                        end else begin
                            o_m_we    <= 1'b0;
                            o_m_add   <= i_if_add;
                            o_m_wdata <= '0;
                            o_m_be    <= '1;
                        end
                    end
                end
                BUSY: begin
                    if (i_m_ack || cnt == CNT_LAST) begin
                        // A real ack wins over a timeout landing on the same edge.
                        o_m_req <= 1'b0;
                        state   <= DONE;
                        if (gnt) begin
                            o_d_ack   <= 1'b1;
                            o_d_err   <= ~i_m_ack;
                            o_d_rdata <= i_m_ack ? i_m_rdata : '0;
                        end else begin
                            o_if_ack   <= 1'b1;
                            o_if_err   <= ~i_m_ack;
                            o_if_rdata <= i_m_ack ? i_m_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    o_m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mem_arbiter.sv
// Directed bench for sc_mem_arbiter: reset, single fetch, store, round-robin,
// timeout, mid-transaction reset and spurious memory acks.
module tb_sc_mem_arbiter;

    localparam int WIDTH = 32;
    localparam int ADD_W = 32;
    localparam int TIMEOUT = 16;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_if_req;
    logic [ADD_W-1:0]   i_if_add;
    logic [WIDTH-1:0]   o_if_rdata;
    logic               o_if_ack;
    logic               o_if_err;
    logic               i_d_req;
    logic               i_d_we;
    logic [ADD_W-1:0]   i_d_add;
    logic [WIDTH-1:0]   i_d_wdata;
    logic [WIDTH/8-1:0] i_d_be;
    logic [WIDTH-1:0]   o_d_rdata;
    logic               o_d_ack;
    logic               o_d_err;
    logic               o_m_req;
    logic               o_m_we;
    logic [ADD_W-1:0]   o_m_add;
    logic [WIDTH-1:0]   o_m_wdata;
    logic [WIDTH/8-1:0] o_m_be;
    logic [WIDTH-1:0]   i_m_rdata;
    logic               i_m_ack;
    logic [1:0]         o_state;

    int checks = 0;
    int failures = 0;

    sc_mem_arbiter #(.WIDTH(WIDTH), .ADD_W(ADD_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_add(i_if_add), .o_if_rdata(o_if_rdata),
        .o_if_ack(o_if_ack), .o_if_err(o_if_err),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_add(i_d_add), .i_d_wdata(i_d_wdata),
        .i_d_be(i_d_be), .o_d_rdata(o_d_rdata), .o_d_ack(o_d_ack), .o_d_err(o_d_err),
        .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_add(o_m_add), .o_m_wdata(o_m_wdata),
        .o_m_be(o_m_be), .i_m_rdata(i_m_rdata), .i_m_ack(i_m_ack), .o_state(o_state)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    // Advance one edge; inputs set afterwards are sampled on the next edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_if_req = 1'b0; i_if_add = '0;
        i_d_req = 1'b0; i_d_we = 1'b0; i_d_add = '0; i_d_wdata = '0; i_d_be = '0;
        i_m_rdata = '0; i_m_ack = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        idle_inputs();
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_m_req, o_m_we, o_m_add, o_m_wdata, o_m_be} !== '0) begin
            failures++;
            $display("FAIL reset_mem got req=%b we=%b add=%h wdata=%h be=%h exp all 0",
                     o_m_req, o_m_we, o_m_add, o_m_wdata, o_m_be);
        end
        checks++;
        if ({o_if_ack, o_if_err, o_if_rdata, o_d_ack, o_d_err, o_d_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_resp got if=%b/%b/%h d=%b/%b/%h exp all 0",
                     o_if_ack, o_if_err, o_if_rdata, o_d_ack, o_d_err, o_d_rdata);
        end
        checks++;
        if (o_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got %0d exp 0", o_state);
        end
    endtask

    task automatic test_single_fetch();
        i_if_req = 1'b1; i_if_add = 32'h0000_1000;
        step();
        checks++;
        if (o_m_req !== 1'b1 || o_m_add !== 32'h0000_1000 || o_m_we !== 1'b0 || o_m_be !== 4'hF || o_m_wdata !== '0) begin
            failures++;
            $display("FAIL fetch_mem got req=%b add=%h we=%b be=%h wdata=%h exp 1/00001000/0/f/0",
                     o_m_req, o_m_add, o_m_we, o_m_be, o_m_wdata);
        end
        checks++;
        if (o_if_ack !== 1'b0 || o_state !== 2'd1) begin
            failures++;
            $display("FAIL fetch_busy got ack=%b state=%0d exp 0/1", o_if_ack, o_state);
        end
        i_m_ack = 1'b1; i_m_rdata = 32'h0050_0093;
        step();
        i_m_ack = 1'b0; i_m_rdata = '0; i_if_req = 1'b0;
        checks++;
        if (o_if_ack !== 1'b1 || o_if_rdata !== 32'h0050_0093 || o_if_err !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack got ack=%b rdata=%h err=%b exp 1/00500093/0", o_if_ack, o_if_rdata, o_if_err);
        end
        checks++;
        if (o_d_ack !== 1'b0 || o_m_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_other got d_ack=%b m_req=%b exp 0/0", o_d_ack, o_m_req);
        end
        step();
        checks++;
        if (o_if_ack !== 1'b0 || o_state !== 2'd0) begin
            failures++;
            $display("FAIL fetch_pulse got ack=%b state=%0d exp 0/0", o_if_ack, o_state);
        end
    endtask

    task automatic test_store();
        i_d_req = 1'b1; i_d_we = 1'b1; i_d_add = 32'h100; i_d_wdata = 32'hDEAD_BEEF; i_d_be = 4'b0011;
        step();
        checks++;
        if (o_m_we !== 1'b1 || o_m_add !== 32'h100 || o_m_wdata !== 32'hDEAD_BEEF || o_m_be !== 4'b0011) begin
            failures++;
            $display("FAIL store_fields got we=%b add=%h wdata=%h be=%b exp 1/00000100/deadbeef/0011",
                     o_m_we, o_m_add, o_m_wdata, o_m_be);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_m_req !== 1'b1) begin
                failures++;
                $display("FAIL store_req cycle %0d got %b exp 1", i, o_m_req);
            end
            if (i == 2) begin
                i_m_ack = 1'b1; i_m_rdata = 32'h5555_AAAA;
            end
            step();
        end
        i_m_ack = 1'b0; i_d_req = 1'b0; i_d_we = 1'b0;
        checks++;
        if (o_d_ack !== 1'b1 || o_d_err !== 1'b0 || o_if_ack !== 1'b0 || o_m_req !== 1'b0) begin
            failures++;
            $display("FAIL store_ack got d_ack=%b d_err=%b if_ack=%b m_req=%b exp 1/0/0/0",
                     o_d_ack, o_d_err, o_if_ack, o_m_req);
        end
        step();
        checks++;
        if (o_d_ack !== 1'b0 || o_if_ack !== 1'b0) begin
            failures++;
            $display("FAIL store_pulse got d_ack=%b if_ack=%b exp 0/0", o_d_ack, o_if_ack);
        end
    endtask

    // Memory acks on the first BUSY cycle of every access.
    task automatic test_round_robin();
        logic [0:0] exp_q[$];
        int         last_cyc;
        int         cyc;
        do_reset();
        i_if_req = 1'b1; i_if_add = 32'h40; i_d_req = 1'b1; i_d_add = 32'h80; i_d_we = 1'b0;
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        last_cyc = -1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 60) begin
            i_m_ack = o_m_req;
            i_m_rdata = o_m_add + 32'h1;
            step();
            cyc++;
            if (o_if_ack === 1'b1 || o_d_ack === 1'b1) begin
                checks++;
                if ((o_d_ack !== exp_q[0]) || (o_if_ack === o_d_ack)) begin
                    failures++;
                    $display("FAIL rr_order got if_ack=%b d_ack=%b exp d_ack=%b", o_if_ack, o_d_ack, exp_q[0]);
                end
                checks++;
                if (last_cyc >= 0 && cyc - last_cyc != 3) begin
                    failures++;
                    $display("FAIL rr_spacing got %0d exp 3", cyc - last_cyc);
                end
                last_cyc = cyc;
                void'(exp_q.pop_front());
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rr_timeout got %0d acks pending exp 0", exp_q.size());
        end
        i_m_ack = 1'b0;
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_timeout();
        int high;
        do_reset();
        i_if_req = 1'b1; i_if_add = 32'h2000;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_add = 32'h300;
        i_m_rdata = 32'h1234_5678;
        step();
        high = 0;
        while (o_m_req === 1'b1 && high < 40) begin
            high++;
            step();
        end
        i_d_req = 1'b0;
        checks++;
        if (high != TIMEOUT) begin
            failures++;
            $display("FAIL to_req_cycles got %0d exp %0d", high, TIMEOUT);
        end
        checks++;
        if (o_d_ack !== 1'b1 || o_d_err !== 1'b1 || o_d_rdata !== '0 || o_if_ack !== 1'b0) begin
            failures++;
            $display("FAIL to_resp got d_ack=%b d_err=%b d_rdata=%h if_ack=%b exp 1/1/0/0",
                     o_d_ack, o_d_err, o_d_rdata, o_if_ack);
        end
        step();
        checks++;
        if (o_m_req !== 1'b0 || o_d_ack !== 1'b0 || o_state !== 2'd0) begin
            failures++;
            $display("FAIL to_idle got m_req=%b d_ack=%b state=%0d exp 0/0/0", o_m_req, o_d_ack, o_state);
        end
        step();
        checks++;
        if (o_m_req !== 1'b1 || o_m_add !== 32'h2000 || o_m_we !== 1'b0) begin
            failures++;
            $display("FAIL to_fetch_grant got req=%b add=%h we=%b exp 1/00002000/0", o_m_req, o_m_add, o_m_we);
        end
        i_m_ack = 1'b1; i_m_rdata = 32'hCAFE_0001;
        step();
        i_m_ack = 1'b0; i_if_req = 1'b0;
        checks++;
        if (o_if_ack !== 1'b1 || o_if_err !== 1'b0 || o_if_rdata !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL to_fetch_ack got ack=%b err=%b rdata=%h exp 1/0/cafe0001", o_if_ack, o_if_err, o_if_rdata);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        int acks;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_add = 32'h200;
        step();
        step();
        checks++;
        if (o_m_req !== 1'b1 || o_state !== 2'd1) begin
            failures++;
            $display("FAIL rm_busy got req=%b state=%0d exp 1/1", o_m_req, o_state);
        end
        i_rst = 1'b1; i_d_req = 1'b0;
        step();
        checks++;
        if (o_m_req !== 1'b0 || o_state !== 2'd0 || o_d_ack !== 1'b0 || o_if_ack !== 1'b0) begin
            failures++;
            $display("FAIL rm_abort got req=%b state=%0d d_ack=%b if_ack=%b exp 0/0/0/0",
                     o_m_req, o_state, o_d_ack, o_if_ack);
        end
        i_rst = 1'b0; i_m_ack = 1'b1; i_m_rdata = 32'hBAD0_BAD0;
        acks = 0;
        step();
        i_m_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (o_d_ack === 1'b1 || o_if_ack === 1'b1 || o_m_req === 1'b1) acks++;
            step();
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL rm_late_ack got %0d active cycles exp 0", acks);
        end
        i_if_req = 1'b1; i_if_add = 32'h3000;
        step();
        checks++;
        if (o_m_req !== 1'b1 || o_m_add !== 32'h3000) begin
            failures++;
            $display("FAIL rm_next_grant got req=%b add=%h exp 1/00003000", o_m_req, o_m_add);
        end
        i_m_ack = 1'b1; i_m_rdata = 32'h0000_0013;
        step();
        i_m_ack = 1'b0; i_if_req = 1'b0;
        checks++;
        if (o_if_ack !== 1'b1 || o_if_rdata !== 32'h0000_0013 || o_d_ack !== 1'b0) begin
            failures++;
            $display("FAIL rm_next_ack got if_ack=%b rdata=%h d_ack=%b exp 1/00000013/0", o_if_ack, o_if_rdata, o_d_ack);
        end
        step();
    endtask

    task automatic test_spurious_ack();
        int bad;
        bad = 0;
        i_m_ack = 1'b1; i_m_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_state !== 2'd0 || o_m_req !== 1'b0 || o_if_ack !== 1'b0 || o_d_ack !== 1'b0) bad++;
        end
        i_m_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sp_idle got %0d disturbed cycles exp 0", bad);
        end
        i_d_req = 1'b1; i_d_we = 1'b1; i_d_add = 32'h44; i_d_wdata = 32'h1; i_d_be = 4'hF;
        step();
        i_m_ack = 1'b1;
        step();
        i_d_req = 1'b0;
        checks++;
        if (o_d_ack !== 1'b1 || o_state !== 2'd2) begin
            failures++;
            $display("FAIL sp_done_entry got d_ack=%b state=%0d exp 1/2", o_d_ack, o_state);
        end
        step();
        checks++;
        if (o_d_ack !== 1'b0 || o_if_ack !== 1'b0 || o_state !== 2'd0 || o_m_req !== 1'b0) begin
            failures++;
            $display("FAIL sp_done got d_ack=%b if_ack=%b state=%0d m_req=%b exp 0/0/0/0",
                     o_d_ack, o_if_ack, o_state, o_m_req);
        end
        step();
        i_m_ack = 1'b0;
        checks++;
        if (o_d_ack !== 1'b0 || o_if_ack !== 1'b0 || o_state !== 2'd0) begin
            failures++;
            $display("FAIL sp_after got d_ack=%b if_ack=%b state=%0d exp 0/0/0", o_d_ack, o_if_ack, o_state);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_store();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_spurious_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
